ramp_gen: RTL and testbench
===========================

# ramp_gen

Carrier generator for the DPWM comparator stage. It produces the 11-bit reference ramp, a phase-shifted copy of that ramp, and the shift-select flag consumed by each phase's duty comparator. Period, shift, shape and shift-select are written through a pending register and applied only at a carrier wrap, so carrier edges stay glitch-free. One instance serves one phase leg.

## Interface

- `DEF_PERIOD`, 1000: period loaded at reset, in clk cycles (sawtooth) or half-cycles (triangle); must be ≥2.
- `clk` input 1: reference clock; all state updates on posedge.
- `rst` input 1: master reset; asynchronous, active-low.
- `en` input 1: count enable; low freezes the counter and all outputs.
- `cfg_wr` input 1: one-cycle strobe; captures `period_in`, `shift_in`, `mode_in`, `shsel_in` into the pending registers.
- `period_in` input 11: requested period P.
- `shift_in` input 12: requested phase shift in counter ticks.
- `mode_in` input 1: 0 = sawtooth, 1 = triangle.
- `shsel_in` input 1: requested shift-select value.
- `ramp_ref` output 11: reference ramp.
- `ramp_ref_s` output 11: shifted ramp.
- `shflag` output 1: shift-select for the comparator.
- `sync` output 1: one-cycle pulse while the counter is 0.
- `cfg_err` output 1: one-cycle pulse flagging a rejected `cfg_wr`.

## Operation

- Internal counter `cnt` (12 bit) runs 0..L-1 and wraps to 0. Sawtooth: L = P. Triangle: L = 2P.
- Fold function: sawtooth value = c. Triangle value = c when c ≤ P, else 2P−c. Triangle range is 0..P.
- `ramp_ref` = fold(cnt).
- Shifted phase ph = cnt + S. If ph ≥ L, then ph − L. `ramp_ref_s` = fold(ph).
- Active config (P, S, mode, shflag) changes only at the wrap, i.e. on the enabled edge where cnt = L−1. Pending values are applied on that edge, and cnt goes to 0 with the new config.
- `cfg_wr` on the wrap edge itself: the new values are applied immediately at that wrap (bypass). Multiple `cfg_wr` before a wrap: the last one wins.
- Validation happens at `cfg_wr`, using the requested mode to compute L:
  - `period_in` < 2 or S ≥ L: the write is discarded, pending is unchanged, and `cfg_err` pulses on the next cycle.
  - Triangle with P > 2047 is impossible, since P is 11 bits.
- `en` low:
  - cnt and all outputs hold.
  - No wrap occurs, so pending config waits.
  - `cfg_wr` is still accepted.
- `sync` = 1 exactly while cnt = 0 and the outputs reflect cnt = 0.

## Timing

- All outputs are registered and change only on posedge clk. There is no combinational path from any input to any output.
- The downstream comparator samples on negedge, which gives a half-cycle margin.
- Outputs are always mutually consistent with the current cnt. The first enabled edge after reset moves cnt from 0 to 1.
- Reset (asynchronous, any time, including mid-period):
  - cnt = 0.
  - Active and pending P = `DEF_PERIOD`, S = 0, mode = 0, shflag = 0.
  - `ramp_ref` = 0, `ramp_ref_s` = 0, `shflag` = 0, `sync` = 1, `cfg_err` = 0.
- Config latency: `cfg_wr` at edge k takes effect at the first wrap at or after edge k.

## Structure

- Shared package `fcml_pwm_pkg` holds:
  - `RAMP_W` = 11 and `CNT_W` = 12.
  - Mode enum with `MODE_SAW` and `MODE_TRI`.
  - A config struct with fields period, shift, mode, shsel. It is used for both the pending and the active register sets.
- Sub-module `ramp_fold` is combinational: it takes cnt/phase, P and mode and returns the 11-bit value. It is instantiated twice, once for `ramp_ref` and once for `ramp_ref_s`.

## Test plan

- Reset, then sawtooth P=4, S=0, en=1:
  - `ramp_ref` = 0,1,2,3,0,1… with `sync` high on every 0.
  - `ramp_ref_s` equals `ramp_ref`.
- Sawtooth P=4, S=2: `ramp_ref_s` = 2,3,0,1,2… while `ramp_ref` = 0,1,2,3,0…
- Triangle P=4, S=4:
  - `ramp_ref` = 0,1,2,3,4,3,2,1,0…
  - `ramp_ref_s` = 4,3,2,1,0,1,2,3,4…
- `cfg_wr` with P=6, shsel=1 at cnt=1 of a P=4 sawtooth: the old ramp finishes (2,3). The new ramp starts at 0 with P=6, and `shflag` rises on the same edge.
- `cfg_wr` with `period_in`=1, then `cfg_wr` with P=4, S=4 in sawtooth mode: `cfg_err` pulses once for each write, and the prior config keeps running unchanged.
- Assert `rst` low mid-period at cnt=3 of a P=8 triangle:
  - Outputs go to 0 immediately and `sync`=1.
  - After release, the block runs at P=`DEF_PERIOD` sawtooth.
  - `en` low for 5 cycles freezes `ramp_ref` at its current value.

Source files
------------

// File: rtl/fcml_pwm_pkg.sv
// fcml_pwm_pkg: shared widths, carrier mode enum, config record and span helper for the DPWM ramp generator
package fcml_pwm_pkg;
  localparam int RAMP_W = 11;
  localparam int CNT_W = 12;
  typedef enum logic {MODE_SAW = 1'b0, MODE_TRI = 1'b1} mode_t;
  typedef struct packed {
    logic [RAMP_W-1:0] period;
    logic [CNT_W-1:0] shift;
    mode_t mode;
    logic shsel;
  } cfg_t;
  function automatic logic [CNT_W-1:0] span(input logic [RAMP_W-1:0] p, input mode_t m);
    return m == MODE_TRI ? {p, 1'b0} : {1'b0, p};
  endfunction
endpackage

// File: rtl/ramp_fold.sv
// ramp_fold: combinational fold of a counter position (pos, period, mode) into the 11-bit sawtooth/triangle value
module ramp_fold
  import fcml_pwm_pkg::*;
(
  input  logic [CNT_W-1:0]  pos,
  input  logic [RAMP_W-1:0] period,
  input  mode_t             mode,
  output logic [RAMP_W-1:0] value
);
  always_comb value = (mode == MODE_TRI && pos > {1'b0, period}) ? RAMP_W'({period, 1'b0} - pos) : pos[RAMP_W-1:0];
endmodule

// File: rtl/ramp_gen.sv
// ramp_gen: registered carrier ramp, shifted ramp, shflag/sync/cfg_err; config staged in a pending set and applied at wrap
module ramp_gen
  import fcml_pwm_pkg::*;
#(
  parameter logic [RAMP_W-1:0] DEF_PERIOD = 11'd1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              cfg_wr,
  input  logic [RAMP_W-1:0] period_in,
  input  logic [CNT_W-1:0]  shift_in,
  input  logic              mode_in,
  input  logic              shsel_in,
  output logic [RAMP_W-1:0] ramp_ref,
  output logic [RAMP_W-1:0] ramp_ref_s,
  output logic              shflag,
  output logic              sync,
  output logic              cfg_err
);
  localparam cfg_t DEF_CFG = '{period: DEF_PERIOD, shift: '0, mode: MODE_SAW, shsel: 1'b0};
  cfg_t act, pend, req, act_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, len_nxt, ph_nxt;
  logic [CNT_W:0] ph_sum;
  logic [RAMP_W-1:0] ref_val, s_val;
  logic req_ok, wrap;
  always_comb begin
    req = '{period: period_in, shift: shift_in, mode: mode_t'(mode_in), shsel: shsel_in};
    req_ok = period_in >= 11'd2 && shift_in < span(period_in, mode_t'(mode_in));
    wrap = en && cnt == span(act.period, act.mode) - 12'd1;
    act_nxt = wrap ? (cfg_wr && req_ok ? req : pend) : act;
    len_nxt = span(act_nxt.period, act_nxt.mode);
    cnt_nxt = wrap ? '0 : cnt + {{(CNT_W-1){1'b0}}, en};
    ph_sum = {1'b0, cnt_nxt} + {1'b0, act_nxt.shift};
    ph_nxt = ph_sum >= {1'b0, len_nxt} ? CNT_W'(ph_sum - {1'b0, len_nxt}) : ph_sum[CNT_W-1:0];
  end
  ramp_fold u_ref (.pos(cnt_nxt), .period(act_nxt.period), .mode(act_nxt.mode), .value(ref_val));
  ramp_fold u_shf (.pos(ph_nxt), .period(act_nxt.period), .mode(act_nxt.mode), .value(s_val));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      act <= DEF_CFG;
      pend <= DEF_CFG;
      ramp_ref <= '0;
      ramp_ref_s <= '0;
      shflag <= 1'b0;
      sync <= 1'b1;
      cfg_err <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      act <= act_nxt;
      pend <= cfg_wr && req_ok ? req : pend;
      ramp_ref <= ref_val;
      ramp_ref_s <= s_val;
      shflag <= act_nxt.shsel;
      sync <= cnt_nxt == '0;
      cfg_err <= cfg_wr && !req_ok;
    end
  end
endmodule

// File: tb/tb_ramp_gen.sv
// tb_ramp_gen: directed-vector self-checking bench for ramp_gen
module tb_ramp_gen;
  import fcml_pwm_pkg::*;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, cfg_wr = 1'b0, mode_in = 1'b0, shsel_in = 1'b0;
  logic [RAMP_W-1:0] period_in = '0;
  logic [CNT_W-1:0] shift_in = '0;
  logic [RAMP_W-1:0] ramp_ref, ramp_ref_s;
  logic shflag, sync, cfg_err;
  int vecs = 0, errs = 0;
  ramp_gen dut (
    .clk(clk), .rst(rst), .en(en), .cfg_wr(cfg_wr), .period_in(period_in), .shift_in(shift_in),
    .mode_in(mode_in), .shsel_in(shsel_in), .ramp_ref(ramp_ref), .ramp_ref_s(ramp_ref_s),
    .shflag(shflag), .sync(sync), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    vecs++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic cyc(input int r, input int s, input int sy);
    step(1);
    check("ramp_ref", ramp_ref, r);
    check("ramp_ref_s", ramp_ref_s, s);
    check("sync", sync, sy);
  endtask
  task automatic wr(input int p, input int s, input int m, input int sh);
    cfg_wr = 1'b1;
    period_in = p[RAMP_W-1:0];
    shift_in = s[CNT_W-1:0];
    mode_in = m[0];
    shsel_in = sh[0];
  endtask
  initial begin
    #2 rst = 1'b0;
    #1;
    check("rst_ref", ramp_ref, 0);
    check("rst_ref_s", ramp_ref_s, 0);
    check("rst_sync", sync, 1);
    check("rst_shflag", shflag, 0);
    check("rst_cfg_err", cfg_err, 0);
    #4 rst = 1'b1;
    wr(4, 0, 0, 0);
    step(1);
    cfg_wr = 1'b0;
    check("ok_wr_no_err", cfg_err, 0);
    check("en_low_hold", ramp_ref, 0);
    en = 1'b1;
    step(999);
    check("def_period_top", ramp_ref, 999);
    cyc(0, 0, 1); cyc(1, 1, 0); cyc(2, 2, 0); cyc(3, 3, 0); cyc(0, 0, 1); cyc(1, 1, 0);
    wr(4, 2, 0, 0);
    cyc(2, 2, 0);
    cfg_wr = 1'b0;
    cyc(3, 3, 0); cyc(0, 2, 1); cyc(1, 3, 0); cyc(2, 0, 0); cyc(3, 1, 0); cyc(0, 2, 1);
    wr(4, 4, 1, 0);
    cyc(1, 3, 0);
    cfg_wr = 1'b0;
    cyc(2, 0, 0); cyc(3, 1, 0);
    cyc(0, 4, 1); cyc(1, 3, 0); cyc(2, 2, 0); cyc(3, 1, 0); cyc(4, 0, 0);
    cyc(3, 1, 0); cyc(2, 2, 0); cyc(1, 3, 0); cyc(0, 4, 1);
    wr(4, 0, 0, 0);
    cyc(1, 3, 0);
    cfg_wr = 1'b0;
    cyc(2, 2, 0); cyc(3, 1, 0); cyc(4, 0, 0); cyc(3, 1, 0); cyc(2, 2, 0); cyc(1, 3, 0);
    cyc(0, 0, 1); cyc(1, 1, 0);
    wr(6, 0, 0, 1);
    cyc(2, 2, 0);
    cfg_wr = 1'b0;
    check("shflag_pre", shflag, 0);
    cyc(3, 3, 0);
    check("shflag_old", shflag, 0);
    cyc(0, 0, 1);
    check("shflag_wrap", shflag, 1);
    cyc(1, 1, 0); cyc(2, 2, 0); cyc(3, 3, 0); cyc(4, 4, 0); cyc(5, 5, 0); cyc(0, 0, 1);
    wr(1, 0, 0, 0);
    cyc(1, 1, 0);
    check("err_p1", cfg_err, 1);
    wr(4, 4, 0, 0);
    cyc(2, 2, 0);
    check("err_s_ge_l", cfg_err, 1);
    cfg_wr = 1'b0;
    cyc(3, 3, 0);
    check("err_clear", cfg_err, 0);
    cyc(4, 4, 0); cyc(5, 5, 0); cyc(0, 0, 1);
    check("shflag_kept", shflag, 1);
    cyc(1, 1, 0); cyc(2, 2, 0); cyc(3, 3, 0); cyc(4, 4, 0); cyc(5, 5, 0); cyc(0, 0, 1);
    wr(8, 0, 1, 1);
    cyc(1, 1, 0);
    cfg_wr = 1'b0;
    cyc(2, 2, 0); cyc(3, 3, 0); cyc(4, 4, 0); cyc(5, 5, 0); cyc(0, 0, 1);
    cyc(1, 1, 0); cyc(2, 2, 0); cyc(3, 3, 0);
    check("shflag_tri", shflag, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_ref", ramp_ref, 0);
    check("arst_ref_s", ramp_ref_s, 0);
    check("arst_sync", sync, 1);
    check("arst_shflag", shflag, 0);
    #3 rst = 1'b1;
    cyc(1, 1, 0); cyc(2, 2, 0); cyc(3, 3, 0); cyc(4, 4, 0); cyc(5, 5, 0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) cyc(5, 5, 0);
    en = 1'b1;
    step(993);
    check("def_after_rst", ramp_ref, 998);
    cyc(999, 999, 0); cyc(0, 0, 1); cyc(1, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
